// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, monitor error flags and FSM states
package vga_pkg;
  localparam int HOR_PIXELS     = 800;
  localparam int VER_PIXELS     = 600;
  localparam int HOR_TOTAL_TIME = 1056;
  localparam int VER_TOTAL_TIME = 628;
  localparam int MON_SIG_W      = 24;
  typedef struct packed {
    logic count_err;
    logic blank_err;
    logic seq_err;
  } vga_err_t;
  typedef enum logic {WAIT_SYNC, MEASURE} mon_state_t;
endpackage

// File: rtl/vga_if.sv
// vga_if: pixel stream bundle passed along the draw chain
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;
  modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport in     (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/vga_frame_sig.sv
// vga_frame_sig: rotate-left-XOR signature register with clear and fold-in enable
module vga_frame_sig
  import vga_pkg::*;
#(
  parameter int W = MON_SIG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [11:0]  data,
  output logic [W-1:0] sig
);
  logic [W-1:0] sig_q, sig_d, base;
  always_comb begin
    base  = clr ? '0 : sig_q;
    sig_d = en ? {base[W-2:0], base[W-1]} ^ W'(data) : base;
  end
  always_ff @(posedge clk)
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  assign sig = sig_q;
endmodule

// File: rtl/vga_stream_monitor.sv
// vga_stream_monitor: passive per-frame checker, pixel counter, signature and probe
module vga_stream_monitor
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = HOR_PIXELS,
  parameter int V_ACTIVE = VER_PIXELS,
  parameter int H_TOTAL  = HOR_TOTAL_TIME,
  parameter int V_TOTAL  = VER_TOTAL_TIME
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           in,
  input  logic [10:0] probe_x,
  input  logic [10:0] probe_y,
  output logic        frame_valid,
  output logic [15:0] frame_cnt,
  output logic [19:0] active_cnt,
  output logic [23:0] signature,
  output logic [11:0] probe_rgb,
  output logic [2:0]  err,
  output logic        err_sticky
);
  localparam logic [10:0] HA   = 11'(H_ACTIVE);
  localparam logic [10:0] VA   = 11'(V_ACTIVE);
  localparam logic [10:0] HT   = 11'(H_TOTAL);
  localparam logic [10:0] VT   = 11'(V_TOTAL);
  localparam logic [19:0] NPIX = 20'(H_ACTIVE * V_ACTIVE);
  logic [10:0] h_q, v_q, ph_q, pv_q, eh, ev;
  logic        hb_q, vb_q, vld_q;
  logic [11:0] rgb_q, probe_q, probe_d;
  logic [19:0] cnt_q, cnt_d;
  logic [23:0] sig;
  mon_state_t  state_q, state_d;
  vga_err_t    chk, errs_q, errs_d, frame_err;
  logic        active, fs, hit, measure, close, h_wrap;
  logic        fv_q, sticky_q;
  logic [15:0] fcnt_q;
  logic [19:0] acnt_q;
  logic [23:0] osig_q;
  logic [11:0] oprobe_q;
  logic [2:0]  oerr_q;
  // vld_q keeps the zeroed reset contents of the input stage from looking like a frame start
  always_ff @(posedge clk)
    if (rst) begin
      {h_q, v_q, ph_q, pv_q} <= '0;
      {hb_q, vb_q, vld_q}    <= '0;
      rgb_q                  <= '0;
    end else begin
      h_q   <= in.hcount;
      v_q   <= in.vcount;
      hb_q  <= in.hblnk;
      vb_q  <= in.vblnk;
      rgb_q <= in.rgb;
      vld_q <= 1'b1;
      ph_q  <= h_q;
      pv_q  <= v_q;
    end
  always_comb begin
    active        = !hb_q && !vb_q;
    fs            = vld_q && h_q == '0 && v_q == '0;
    hit           = active && h_q == probe_x && v_q == probe_y;
    measure       = state_q == MEASURE;
    close         = measure && fs;
    h_wrap        = ph_q == HT - 11'd1;
    eh            = h_wrap ? '0 : ph_q + 11'd1;
    ev            = h_wrap ? (pv_q == VT - 11'd1 ? '0 : pv_q + 11'd1) : pv_q;
    chk.seq_err   = h_q != eh || v_q != ev;
    chk.blank_err = hb_q != (h_q >= HA) || vb_q != (v_q >= VA);
    chk.count_err = 1'b0;
    frame_err     = vga_err_t'({cnt_q != NPIX, errs_q.blank_err, errs_q.seq_err});
    state_d       = fs ? MEASURE : state_q;
    cnt_d         = (fs ? '0 : cnt_q) + 20'(active);
    probe_d       = hit ? rgb_q : fs ? '0 : probe_q;
    // the fs pixel's own checks belong to the frame it opens
    errs_d        = vga_err_t'((fs ? 3'b000 : errs_q) | (measure ? chk : 3'b000));
  end
  vga_frame_sig u_sig (
    .clk  (clk),
    .rst  (rst),
    .clr  (fs),
    .en   (active),
    .data (rgb_q),
    .sig  (sig)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= WAIT_SYNC;
      cnt_q   <= '0;
      probe_q <= '0;
      errs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      probe_q <= probe_d;
      errs_q  <= errs_d;
    end
  always_ff @(posedge clk)
    if (rst) begin
      fv_q     <= 1'b0;
      fcnt_q   <= '0;
      acnt_q   <= '0;
      osig_q   <= '0;
      oprobe_q <= '0;
      oerr_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      fv_q <= close;
      if (close) begin
        fcnt_q   <= fcnt_q + 16'd1;
        acnt_q   <= cnt_q;
        osig_q   <= sig;
        oprobe_q <= probe_q;
        oerr_q   <= frame_err;
        sticky_q <= sticky_q | (|frame_err);
      end
    end
  assign frame_valid = fv_q;
  assign frame_cnt   = fcnt_q;
  assign active_cnt  = acnt_q;
  assign signature   = osig_q;
  assign probe_rgb   = oprobe_q;
  assign err         = oerr_q;
  assign err_sticky  = sticky_q;
endmodule

// File: tb/tb_vga_stream_monitor.sv
// tb_vga_stream_monitor: directed frames with hand-computed results, checked by a frame_valid scoreboard
module tb_vga_stream_monitor;
  typedef struct {
    logic [31:0] cnt;
    logic [31:0] act;
    logic [31:0] sig;
    logic [31:0] probe;
    logic [31:0] err;
    logic [31:0] sticky;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] probe_x = '0, probe_y = '0;
  logic        frame_valid, err_sticky;
  logic [15:0] frame_cnt;
  logic [19:0] active_cnt;
  logic [23:0] signature;
  logic [11:0] probe_rgb;
  logic [2:0]  err;
  int          vectors = 0, miscompares = 0;
  exp_t        q[$];
  exp_t        pend;
  bit          have_pend = 0;
  bit          pix_en = 0, glitch = 0, fblank = 0;
  int          px = 0, py = 0;
  vga_if vif ();
  vga_stream_monitor #(.H_ACTIVE(8), .V_ACTIVE(4), .H_TOTAL(12), .V_TOTAL(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (vif),
    .probe_x     (probe_x),
    .probe_y     (probe_y),
    .frame_valid (frame_valid),
    .frame_cnt   (frame_cnt),
    .active_cnt  (active_cnt),
    .signature   (signature),
    .probe_rgb   (probe_rgb),
    .err         (err),
    .err_sticky  (err_sticky)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " frame_valid"}, 32'(frame_valid), 0);
    chk({tag, " frame_cnt"},   32'(frame_cnt),   0);
    chk({tag, " active_cnt"},  32'(active_cnt),  0);
    chk({tag, " signature"},   32'(signature),   0);
    chk({tag, " probe_rgb"},   32'(probe_rgb),   0);
    chk({tag, " err"},         32'(err),         0);
    chk({tag, " err_sticky"},  32'(err_sticky),  0);
  endtask
  task automatic idle();
    vif.hcount = 11'd11; vif.vcount = 11'd5;
    vif.hblnk = 1'b1; vif.vblnk = 1'b1;
    vif.hsync = 1'b0; vif.vsync = 1'b0; vif.rgb = '0;
  endtask
  function automatic exp_t mk(int c, int a, int s, int p, int e, int st);
    mk = '{32'(c), 32'(a), 32'(s), 32'(p), 32'(e), 32'(st)};
  endfunction
  // each frame's results appear two edges into the following frame, so queue the previous one here
  task automatic run_frame(input exp_t e, input int ncyc);
    int n = 0;
    if (have_pend) q.push_back(pend);
    pend = e;
    have_pend = 1;
    for (int v = 0; v < 6; v++)
      for (int h = 0; h < 12; h++)
        if (n < ncyc) begin
          @(negedge clk);
          vif.hcount = (glitch && v == 2 && h == 6) ? 11'd7 : 11'(h);
          vif.vcount = 11'(v);
          vif.hblnk  = h >= 8 || (fblank && h == 3 && v == 1);
          vif.vblnk  = v >= 4;
          vif.hsync  = h == 9;
          vif.vsync  = v == 5;
          vif.rgb    = (pix_en && h == px && v == py) ? 12'h123 : 12'h000;
          n++;
        end
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (frame_valid === 1'b1) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected frame_valid: frame_cnt 0x%0h, no result expected", frame_cnt);
      end else begin
        e = q.pop_front();
        chk("frame_cnt",  32'(frame_cnt),  e.cnt);
        chk("active_cnt", 32'(active_cnt), e.act);
        chk("signature",  32'(signature),  e.sig);
        chk("probe_rgb",  32'(probe_rgb),  e.probe);
        chk("err",        32'(err),        e.err);
        chk("err_sticky", 32'(err_sticky), e.sticky);
      end
    end
  end
  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst = 1'b0;
    run_frame(mk(1, 32, 0, 0, 0, 0), 72);
    run_frame(mk(2, 32, 0, 0, 0, 0), 72);
    run_frame(mk(3, 32, 0, 0, 0, 0), 72);
    pix_en = 1; px = 0; py = 0;
    run_frame(mk(4, 32, 'h009180, 'h123, 0, 0), 72);
    px = 7; py = 3; probe_x = 11'd7; probe_y = 11'd3;
    run_frame(mk(5, 32, 'h000123, 'h123, 0, 0), 72);
    probe_x = 11'd9; probe_y = 11'd2;
    run_frame(mk(6, 32, 'h000123, 0, 0, 0), 72);
    pix_en = 0; glitch = 1;
    run_frame(mk(7, 32, 0, 0, 'b001, 1), 72);
    glitch = 0;
    run_frame(mk(8, 32, 0, 0, 0, 1), 72);
    fblank = 1;
    run_frame(mk(9, 31, 0, 0, 'b110, 1), 72);
    fblank = 0;
    run_frame(mk(10, 32, 0, 0, 0, 1), 72);
    run_frame(mk(0, 0, 0, 0, 0, 0), 30);
    have_pend = 0;
    chk("pre-reset frame_cnt", 32'(frame_cnt), 10);
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1 chk_zero("mid reset");
    @(negedge clk) rst = 1'b0;
    run_frame(mk(1, 32, 0, 0, 0, 0), 72);
    run_frame(mk(2, 32, 0, 0, 0, 0), 72);
    run_frame(mk(0, 0, 0, 0, 0, 0), 72);
    have_pend = 0;
    @(negedge clk) idle();
    repeat (10) @(posedge clk);
    #2 chk("results outstanding", 32'(q.size()), 0);
    chk("final frame_cnt", 32'(frame_cnt), 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
